// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial preamble-framed, even-parity-checked configuration loader for the CLB
module clb_cfg_loader #(
   parameter int               CFG_W    = 37,
   parameter int               PRE_W    = 8,
   parameter logic [PRE_W-1:0] PREAMBLE = 8'hF2,
   parameter logic [CFG_W-1:0] CFG_RST  = 37'h022C54038
) (
   input  logic             K,
   input  logic             RST_N,
   input  logic             DIN,
   input  logic             DIN_VLD,
   output logic [CFG_W-1:0] CFG,
   output logic             CFG_VLD,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);
   localparam int BC_W = $clog2(CFG_W);
   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;

   logic [1:0]       state;
   logic [PRE_W-1:0] window;
   logic [CFG_W-1:0] shadow;
   logic [BC_W-1:0]  bitcnt;
   logic [PRE_W-1:0] window_nxt;

   assign window_nxt = {window[PRE_W-2:0], DIN};
   assign BUSY       = state != HUNT;

   // Frame FSM: hunt preamble, shift payload, commit only on good parity
   always_ff @(posedge K or negedge RST_N) begin
      if (!RST_N) begin
         state   <= HUNT;
         window  <= '0;
         shadow  <= '0;
         bitcnt  <= '0;
         CFG     <= CFG_RST;
         CFG_VLD <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         if (DIN_VLD) begin
            case (state)
               HUNT: begin
                  window <= window_nxt;
                  if (window_nxt == PREAMBLE) begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end
               end
               DATA: begin
                  shadow <= {shadow[CFG_W-2:0], DIN};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == BC_W'(CFG_W-1)) state <= PARITY;
               end
               PARITY: begin
                  if (^{shadow, DIN} == 1'b0) begin
                     CFG     <= shadow;
                     CFG_VLD <= 1'b1;
                     DONE    <= 1'b1;
                  end else begin
                     ERR <= 1'b1;
                  end
                  state  <= HUNT;
                  window <= '0;
               end
               default: state <= HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: scoreboard bench for the serial CLB configuration loader
module tb_clb_cfg_loader;
   localparam logic [36:0] CFG_RST = 37'h022C54038;
   localparam logic [7:0]  PRE     = 8'hF2;

   typedef struct {
      logic        good;
      logic [36:0] cfg;
      logic        vld;
   } exp_t;

   logic        K = 1'b0;
   logic        RST_N = 1'b0;
   logic        DIN = 1'b0;
   logic        DIN_VLD = 1'b0;
   logic [36:0] CFG;
   logic        CFG_VLD, BUSY, DONE, ERR;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   logic [36:0] exp_cfg = CFG_RST;
   logic        exp_vld = 1'b0;

   clb_cfg_loader dut (
      .K(K), .RST_N(RST_N), .DIN(DIN), .DIN_VLD(DIN_VLD),
      .CFG(CFG), .CFG_VLD(CFG_VLD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 K = ~K;

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      DIN = b;
      DIN_VLD = 1'b1;
      @(posedge K);
      #1;
   endtask

   task automatic idle(input int n);
      DIN_VLD = 1'b0;
      repeat (n) @(posedge K);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   // parity bit chosen to make the total even when good, odd otherwise
   task automatic send_frame(input logic [36:0] f, input logic good, input logic stall);
      exp_t e;
      send_byte(PRE);
      check("busy_after_preamble", {36'd0, BUSY}, 37'd1);
      for (int i = 36; i >= 0; i--) begin
         if (stall && (i % 5 == 4)) begin
            idle(3);
            check("busy_in_stall", {36'd0, BUSY}, 37'd1);
         end
         send_bit(f[i]);
      end
      check("busy_before_parity", {36'd0, BUSY}, 37'd1);
      if (good) begin
         exp_cfg = f;
         exp_vld = 1'b1;
      end
      e.good = good;
      e.cfg  = exp_cfg;
      e.vld  = exp_vld;
      q.push_back(e);
      send_bit(good ? ^f : ~^f);
      check("busy_after_parity", {36'd0, BUSY}, 37'd0);
      DIN_VLD = 1'b0;
   endtask

   // Monitor: every DONE/ERR pulse must match the oldest expected outcome
   always @(negedge K) begin
      if (DONE || ERR) begin
         check("done_err_exclusive", {36'd0, DONE & ERR}, 37'd0);
         if (q.size() == 0) begin
            check("unexpected_pulse", {35'd0, DONE, ERR}, 37'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_kind", {35'd0, DONE, ERR}, {35'd0, e.good, ~e.good});
            check("pulse_cfg", CFG, e.cfg);
            check("pulse_cfg_vld", {36'd0, CFG_VLD}, {36'd0, e.vld});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0;
      repeat (3) @(posedge K);
      #1;
      check("rst_cfg", CFG, CFG_RST);
      check("rst_cfg_vld", {36'd0, CFG_VLD}, 37'd0);
      check("rst_busy", {36'd0, BUSY}, 37'd0);
      check("rst_done", {36'd0, DONE}, 37'd0);
      check("rst_err", {36'd0, ERR}, 37'd0);
      RST_N = 1'b1;
      idle(2);

      // bad parity: nothing committed, back in HUNT
      send_frame(37'h1_2345_6789, 1'b0, 1'b0);
      idle(2);
      check("bad_cfg_kept", CFG, CFG_RST);
      check("bad_cfg_vld", {36'd0, CFG_VLD}, 37'd0);
      check("bad_in_hunt", {36'd0, BUSY}, 37'd0);

      // good frame
      send_frame(37'h1_2345_6789, 1'b1, 1'b0);
      idle(2);
      check("good_cfg", CFG, 37'h1_2345_6789);
      check("good_cfg_vld", {36'd0, CFG_VLD}, 37'd1);

      // leading ones before the preamble, stalls inside the payload
      send_byte(8'hFF);
      send_frame(37'h0_0BAD_CAFE, 1'b1, 1'b1);
      idle(2);
      check("stall_cfg", CFG, 37'h0_0BAD_CAFE);

      // reset mid-frame at data bit 20
      send_byte(PRE);
      for (int i = 36; i > 16; i--) send_bit(i[0]);
      DIN_VLD = 1'b0;
      RST_N = 1'b0;
      #1;
      check("midrst_cfg", CFG, CFG_RST);
      check("midrst_busy", {36'd0, BUSY}, 37'd0);
      check("midrst_cfg_vld", {36'd0, CFG_VLD}, 37'd0);
      exp_cfg = CFG_RST;
      exp_vld = 1'b0;
      @(posedge K);
      #1;
      RST_N = 1'b1;
      idle(1);
      send_frame(37'h1_5555_AAAA, 1'b1, 1'b0);
      idle(2);
      check("after_rst_cfg", CFG, 37'h1_5555_AAAA);

      // back to back: A, B (payload holds the preamble pattern), then bad C
      send_frame(37'h1_F0F0_F0F0, 1'b1, 1'b0);
      send_frame(37'h0_F2F2_F2F2, 1'b1, 1'b0);
      send_frame(37'h1_0000_0001, 1'b0, 1'b0);
      idle(3);
      check("b2b_final_cfg", CFG, 37'h0_F2F2_F2F2);
      check("b2b_final_vld", {36'd0, CFG_VLD}, 37'd1);
      check("scoreboard_drained", 37'(q.size()), 37'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
